// File: rtl/au.sv
`default_nettype none
// ============================================================================
//  Module      : au
//  Description : 16-bit arithmetic unit with a 4-bit command. Performs
//                ADD / SUB with carry-out and signed overflow, plus optional
//                saturating operations: PADDSW (four signed 4-bit lanes) and
//                SADD16 (16-bit signed saturating add). All outputs are
//                registered; latency is one cycle and a new operation can be
//                accepted on every cycle.
//
//  Command decode (only Cmd[3] and Cmd[1] matter):
//      0?0?  ADD     Result = A + B, cout = carry, ovf = signed overflow
//      0?1?  SUB     Result = A - B, cout = no-borrow, ovf = signed overflow
//      1?0?  PADDSW  four signed 4-bit saturating lane adds   (AU_SAT_EN)
//      1?1?  SADD16  16-bit signed saturating add             (AU_SAT_EN)
//
//  Configuration macro:
//      AU_SAT_EN  defined   : PADDSW / SADD16 are implemented.
//                 undefined : Cmd[3] is ignored (1?0? = ADD, 1?1? = SUB) and
//                             the saturation logic is not built.
//
//  Ports:
//      clk        in   1   rising-edge clock
//      rst        in   1   synchronous active-high reset
//      in_valid   in   1   operands/command valid this cycle
//      Cmd        in   4   operation select
//      A          in   16  operand A
//      B          in   16  operand B
//      Result     out  16  registered result
//      cout       out  1   registered carry-out (0 for saturating ops)
//      ovf        out  1   registered signed overflow / saturation flag
//      out_valid  out  1   Result/cout/ovf updated on the previous edge
//
//  Revision    : 1.0  initial release
// ============================================================================
module au (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  Cmd,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Result,
    output logic        cout,
    output logic        ovf,
    output logic        out_valid
);

    logic        w_sub;
    logic [15:0] w_b_op;
    logic [16:0] w_sum;
    logic        w_ovf_arith;
    logic [15:0] w_res;
    logic        w_cout;
    logic        w_ovf;
    logic        unused_cmd;

`ifdef AU_SAT_EN
    // Saturating commands always add, so subtraction only for 0?1?.
    assign w_sub      = Cmd[1] & ~Cmd[3];
    assign unused_cmd = ^{Cmd[2], Cmd[0]};
`else
    assign w_sub      = Cmd[1];
    assign unused_cmd = ^{Cmd[3], Cmd[2], Cmd[0]};
`endif

    // Single adder: SUB is A + ~B + 1, so bit 16 is the no-borrow flag.
    assign w_b_op      = w_sub ? ~B : B;
    assign w_sum       = {1'b0, A} + {1'b0, w_b_op} + {16'd0, w_sub};
    // Signed overflow: both addends share a sign that the sum does not.
    assign w_ovf_arith = (A[15] == w_b_op[15]) && (w_sum[15] != A[15]);

`ifdef AU_SAT_EN
    logic [15:0] w_lane_res;
    logic [3:0]  w_lane_sat;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            logic [4:0] w_ls;
            // 5-bit sign-extended lane sum; bits 4 and 3 disagree on overflow,
            // and bit 4 then holds the true sign of the result.
            assign w_ls = {A[4*i+3], A[4*i +: 4]} + {B[4*i+3], B[4*i +: 4]};
            assign w_lane_sat[i]      = w_ls[4] ^ w_ls[3];
            assign w_lane_res[4*i +: 4] = w_lane_sat[i] ? (w_ls[4] ? 4'h8 : 4'h7)
                                                        : w_ls[3:0];
        end
    endgenerate

    always_comb begin
        w_res  = w_sum[15:0];
        w_cout = w_sum[16];
        w_ovf  = w_ovf_arith;
        if (Cmd[3]) begin
            w_cout = 1'b0;
            if (Cmd[1]) begin
                // SADD16: clamp toward the sign shared by both operands.
                if (w_ovf_arith) begin
                    w_res = A[15] ? 16'h8000 : 16'h7FFF;
                end
            end else begin
                w_res = w_lane_res;
                w_ovf = |w_lane_sat;
            end
        end
    end
`else
    assign w_res  = w_sum[15:0];
    assign w_cout = w_sum[16];
    assign w_ovf  = w_ovf_arith;
`endif

    // Outputs hold their last value when no new operation is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            Result    <= 16'h0000;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Result    <= w_res;
            cout      <= w_cout;
            ovf       <= w_ovf;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_au.sv
`default_nettype none
// ============================================================================
//  Module      : tb_au
//  Description : Self-checking bench for au. A register-level reference of
//                the outputs is updated whenever stimulus is driven and the
//                expected output state is queued; one edge later it is popped
//                and compared with the DUT. Directed vectors come from a
//                table, sweeps and random traffic from an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_au;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  Cmd = 4'h0;
    logic [15:0] A = 16'h0;
    logic [15:0] B = 16'h0;
    logic [15:0] Result;
    logic        cout;
    logic        ovf;
    logic        out_valid;

    au dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .Cmd       (Cmd),
        .A         (A),
        .B         (B),
        .Result    (Result),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic        co;
        logic        ov;
        logic        vld;
    } exp_t;

    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    exp_t q[$];
    exp_t m_state = '{16'h0, 1'b0, 1'b0, 1'b0};
    int   checks   = 0;
    int   failures = 0;

    // Independent arithmetic reference built on integer math.
    function automatic exp_t model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          sa;
        int          sb;
        int          s;
        int          la;
        int          lb;
        int          ls;
        logic [31:0] u;
        logic [31:0] lv;
        logic        sat;
        sa  = $signed(a);
        sb  = $signed(b);
        sat = 1'b0;
`ifdef AU_SAT_EN
        sat = c[3];
`endif
        e.vld = 1'b1;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        e.res = 16'h0;
        if (!sat && !c[1]) begin
            u     = 32'(a) + 32'(b);
            e.res = u[15:0];
            e.co  = u[16];
            s     = sa + sb;
            e.ov  = (s > 32767) || (s < -32768);
        end else if (!sat) begin
            u     = 32'(a) - 32'(b);
            e.res = u[15:0];
            e.co  = (a >= b);
            s     = sa - sb;
            e.ov  = (s > 32767) || (s < -32768);
        end else if (!c[1]) begin
            for (int i = 0; i < 4; i++) begin
                la = $signed(a[4*i +: 4]);
                lb = $signed(b[4*i +: 4]);
                ls = la + lb;
                if (ls > 7)  begin ls = 7;  e.ov = 1'b1; end
                if (ls < -8) begin ls = -8; e.ov = 1'b1; end
                lv = ls;
                e.res[4*i +: 4] = lv[3:0];
            end
        end else begin
            s = sa + sb;
            if (s > 32767)       begin s = 32767;  e.ov = 1'b1; end
            else if (s < -32768) begin s = -32768; e.ov = 1'b1; end
            lv    = s;
            e.res = lv[15:0];
        end
        return e;
    endfunction

    // Pop the expectation for the most recent edge and compare it.
    task automatic check_pending();
        exp_t e;
        if (q.size() == 0) return;
        e = q.pop_front();
        checks++;
        if (out_valid !== e.vld) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid, e.vld, $time);
        end
        checks++;
        if (Result !== e.res) begin
            failures++;
            $display("FAIL Result: got %h expected %h (t=%0t)", Result, e.res, $time);
        end
        checks++;
        if (cout !== e.co) begin
            failures++;
            $display("FAIL cout: got %b expected %b (t=%0t)", cout, e.co, $time);
        end
        checks++;
        if (ovf !== e.ov) begin
            failures++;
            $display("FAIL ovf: got %b expected %b (t=%0t)", ovf, e.ov, $time);
        end
    endtask

    // Drive one cycle of stimulus with an explicit expected operation result.
    task automatic drive(input logic r, input logic v, input logic [3:0] c,
                         input logic [15:0] a, input logic [15:0] b, input exp_t op);
        @(negedge clk);
        check_pending();
        rst      = r;
        in_valid = v;
        Cmd      = c;
        A        = a;
        B        = b;
        if (r) begin
            m_state = '{16'h0, 1'b0, 1'b0, 1'b0};
        end else if (v) begin
            m_state     = op;
            m_state.vld = 1'b1;
        end else begin
            m_state.vld = 1'b0;
        end
        q.push_back(m_state);
    endtask

    task automatic drive_model(input logic r, input logic v, input logic [3:0] c,
                               input logic [15:0] a, input logic [15:0] b);
        drive(r, v, c, a, b, model(c, a, b));
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{4'h5, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{4'h2, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1});
        vecs.push_back('{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{4'h7, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{4'h0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0});
`ifdef AU_SAT_EN
        vecs.push_back('{4'h8, 16'h7788, 16'h1188, 16'h7788, 1'b0, 1'b1});
        vecs.push_back('{4'hD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0});
        vecs.push_back('{4'hA, 16'h7000, 16'h2000, 16'h7FFF, 1'b0, 1'b1});
        vecs.push_back('{4'hF, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{4'hB, 16'h1000, 16'hF000, 16'h0000, 1'b0, 1'b0});
`else
        vecs.push_back('{4'h8, 16'h7788, 16'h1188, 16'h8910, 1'b0, 1'b1});
        vecs.push_back('{4'hD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0});
        vecs.push_back('{4'hA, 16'h7000, 16'h2000, 16'h5000, 1'b1, 1'b0});
        vecs.push_back('{4'hF, 16'h8000, 16'hFFFF, 16'h8001, 1'b0, 1'b0});
        vecs.push_back('{4'hB, 16'h1000, 16'hF000, 16'h2000, 1'b0, 1'b0});
`endif

        // Reset state.
        drive_model(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
        drive_model(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);

        // Directed vectors, back-to-back.
        foreach (vecs[i]) begin
            drive(1'b0, 1'b1, vecs[i].cmd, vecs[i].a, vecs[i].b,
                  '{vecs[i].res, vecs[i].co, vecs[i].ov, 1'b1});
        end

        // Idle cycle: out_valid drops, outputs hold.
        drive_model(1'b0, 1'b0, 4'h3, 16'hAAAA, 16'h5555);

        // SUB sweep, one operation per cycle.
        for (int k = 0; k < 300; k++) begin
            drive_model(1'b0, 1'b1, 4'h2, 16'(20000 + 7 * k), 16'(3 * k));
        end

        // Random mix including gaps.
        for (int k = 0; k < 300; k++) begin
            drive_model(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                        16'($urandom), 16'($urandom));
        end

        // Reset while valid discards the operation; then an idle cycle holds zero.
        drive_model(1'b0, 1'b1, 4'h0, 16'h1234, 16'h4321);
        drive_model(1'b1, 1'b1, 4'h0, 16'h1111, 16'h2222);
        drive_model(1'b0, 1'b0, 4'h0, 16'h3333, 16'h4444);
        // First valid input after reset appears one cycle later, then holds.
        drive_model(1'b0, 1'b1, 4'h0, 16'h0102, 16'h0304);
        drive_model(1'b0, 1'b0, 4'h2, 16'hFFFF, 16'h0001);
        drive_model(1'b0, 1'b0, 4'h2, 16'hFFFF, 16'h0001);
        drive_model(1'b0, 1'b1, 4'h2, 16'h8000, 16'h0001);

        @(negedge clk);
        check_pending();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
